// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async_fifo producer front end: writer FSM encoding
// and FIFO word field positions.
package async_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_ABORT  = 2'd2,
    ST_DROP   = 2'd3
  } wr_state_e;

  // FIFO word layout is {err,last,data}
  function automatic int unsigned err_bit(input int unsigned dsize);
    return dsize + 1;
  endfunction

  function automatic int unsigned last_bit(input int unsigned dsize);
    return dsize;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer. The owner decides push/pop/flush; occ_next_c exposes the
// next occupancy so the owner can register its upstream ready.
module stream_skid_buf #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         head_valid,
  output logic [W-1:0] head_data,
  output logic [1:0]   occ_next_c
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   occ_q, occ_d, occ_mid;
  logic         valid_q, valid_d;

  // Pop shifts entry 1 forward, then a push lands in the first free slot
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    occ_mid = occ_q;
    occ_d   = occ_q;
    if (pop && (occ_q != 2'd0)) begin
      ent0_d  = ent1_q;
      occ_mid = occ_q - 2'd1;
    end
    occ_d = occ_mid;
    if (push && (occ_mid != 2'd2)) begin
      if (occ_mid == 2'd0) begin
        ent0_d = push_data;
      end else begin
        ent1_d = push_data;
      end
      occ_d = occ_mid + 2'd1;
    end
    if (flush) begin
      occ_d = 2'd0;
    end
    valid_d = (occ_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      occ_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
    end
  end

  assign head_valid = valid_q;
  assign head_data  = ent0_q;
  assign occ_next_c = occ_d;

endmodule

// File: rtl/async_fifo_stream_writer.sv
// Producer-side front end for async_fifo: packs a valid/ready packet stream into
// {err,last,data} FIFO words, gates packet starts on almost_full, handles abort.
module async_fifo_stream_writer
  import async_fifo_pkg::*;
#(
  parameter int unsigned DSIZE    = 8,
  parameter int unsigned PKT_GATE = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DSIZE-1:0]   s_data,
  input  logic               s_last,
  input  logic               s_abort,
  output logic               winc,
  output logic [DSIZE+1:0]   wdata,
  input  logic               wfull,
  input  logic               almost_full,
  input  logic               overflow_error,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]   abort_cnt,
  output logic               ovf_seen
);

  localparam int unsigned BW       = DSIZE + 1;
  localparam int unsigned WW       = DSIZE + 2;
  localparam int unsigned ERR_BIT  = err_bit(DSIZE);
  localparam int unsigned LAST_BIT = last_bit(DSIZE);

  wr_state_e        state_q, state_d;
  logic             s_ready_q, s_ready_d;
  logic             winc_q, winc_d;
  logic [WW-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] abort_cnt_q, abort_cnt_d;
  logic             ovf_q, ovf_d;
  logic             abort_last_q, abort_last_d;

  logic             push, pop, flush;
  logic             head_valid;
  logic [BW-1:0]    head_data;
  logic [1:0]       occ_next_c;
  logic             acc, gate_ok, pkt_inc, abort_inc;

  stream_skid_buf #(.W(BW)) u_skid (
    .clk        (wclk),
    .rst_n      (wrst_n),
    .flush      (flush),
    .push       (push),
    .push_data  ({s_last, s_data}),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .occ_next_c (occ_next_c)
  );

  assign acc     = s_valid && s_ready_q;
  assign gate_ok = (PKT_GATE == 0) || !almost_full;

  always_comb begin
    state_d      = state_q;
    winc_d       = 1'b0;
    wdata_d      = wdata_q;
    abort_last_d = abort_last_q;
    push         = 1'b0;
    pop          = 1'b0;
    flush        = 1'b0;
    pkt_inc      = 1'b0;
    abort_inc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        push = acc;
        if (head_valid && !wfull && gate_ok) begin
          winc_d  = 1'b1;
          wdata_d = {1'b0, head_data};
          pop     = 1'b1;
          if (head_data[LAST_BIT]) pkt_inc = 1'b1;
          else                     state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (s_abort) begin
          // Abort wins over a coincident beat; its last flag decides the exit
          flush        = 1'b1;
          abort_last_d = acc && s_last;
          state_d      = ST_ABORT;
        end else begin
          push = acc;
          if (head_valid && !wfull) begin
            winc_d  = 1'b1;
            wdata_d = {1'b0, head_data};
            pop     = 1'b1;
            if (head_data[LAST_BIT]) begin
              pkt_inc = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_ABORT: begin
        if (!wfull) begin
          winc_d            = 1'b1;
          wdata_d           = '0;
          wdata_d[ERR_BIT]  = 1'b1;
          wdata_d[LAST_BIT] = 1'b1;
          abort_inc         = 1'b1;
          state_d           = abort_last_q ? ST_IDLE : ST_DROP;
        end
      end
      ST_DROP: begin
        if (acc && s_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Ready reflects next-cycle room; DROP swallows beats, ABORT stalls them
    s_ready_d = (state_d == ST_DROP) ||
                ((state_d != ST_ABORT) && (occ_next_c <= 2'd1));

    pkt_cnt_d = pkt_cnt_q;
    if (pkt_inc && (pkt_cnt_q != {CNT_W{1'b1}})) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
    abort_cnt_d = abort_cnt_q;
    if (abort_inc && (abort_cnt_q != {CNT_W{1'b1}})) abort_cnt_d = abort_cnt_q + CNT_W'(1);
    ovf_d = ovf_q || overflow_error;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q      <= ST_IDLE;
      s_ready_q    <= 1'b0;
      winc_q       <= 1'b0;
      wdata_q      <= '0;
      pkt_cnt_q    <= '0;
      abort_cnt_q  <= '0;
      ovf_q        <= 1'b0;
      abort_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_ready_q    <= s_ready_d;
      winc_q       <= winc_d;
      wdata_q      <= wdata_d;
      pkt_cnt_q    <= pkt_cnt_d;
      abort_cnt_q  <= abort_cnt_d;
      ovf_q        <= ovf_d;
      abort_last_q <= abort_last_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign winc      = winc_q;
  assign wdata     = wdata_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign abort_cnt = abort_cnt_q;
  assign ovf_seen  = ovf_q;

endmodule
